// File: rtl/cbfp_block_norm.sv
// Block-floating-point normaliser: one shared real/imag shift per block of beats, ping-pong buffered.
// Optional feature macro CBFP_ROUND_EN: round half up with positive saturation instead of truncation.
module cbfp_block_norm #(
  parameter int LANES           = 16,
  parameter int IN_WIDTH        = 25,
  parameter int OUT_WIDTH       = 12,
  parameter int BEATS_PER_BLOCK = 4,
  parameter int SHIFT_WIDTH     = 5
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          din_valid,
  input  logic signed [IN_WIDTH-1:0]    din_i [LANES],
  input  logic signed [IN_WIDTH-1:0]    din_q [LANES],
  output logic                          valid_out,
  output logic signed [OUT_WIDTH-1:0]   dout_i [LANES],
  output logic signed [OUT_WIDTH-1:0]   dout_q [LANES],
  output logic [SHIFT_WIDTH-1:0]        index_re,
  output logic [SHIFT_WIDTH-1:0]        index_im
);

  localparam int CNT_W = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;
  localparam logic [CNT_W-1:0]              LAST_BEAT = CNT_W'(BEATS_PER_BLOCK - 1);
  localparam logic [SHIFT_WIDTH-1:0]        MAG_MAX   = SHIFT_WIDTH'(IN_WIDTH - 1);
  localparam logic signed [OUT_WIDTH-1:0]   OUT_MAX   = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  // Count of bits below the sign bit that repeat the sign bit.
  function automatic logic [SHIFT_WIDTH-1:0] lead_sign(input logic signed [IN_WIDTH-1:0] x);
    logic [SHIFT_WIDTH-1:0] n;
    logic                   run;
    n   = '0;
    run = 1'b1;
    for (int b = IN_WIDTH - 2; b >= 0; b--) begin
      if (run && (x[b] == x[IN_WIDTH-1])) n = n + SHIFT_WIDTH'(1);
      else                                run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [SHIFT_WIDTH-1:0] min_sh(input logic [SHIFT_WIDTH-1:0] a,
                                                    input logic [SHIFT_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Upper OUT_WIDTH bits of the shifted sample; the rounding carry can only overflow upward.
  function automatic logic signed [OUT_WIDTH-1:0] normalise(input logic signed [IN_WIDTH-1:0] x,
                                                            input logic [SHIFT_WIDTH-1:0] sh);
    logic signed [IN_WIDTH-1:0]  s;
    logic signed [OUT_WIDTH-1:0] t;
    s = x <<< sh;
    t = s[IN_WIDTH-1 -: OUT_WIDTH];
`ifdef CBFP_ROUND_EN
    if (s[IN_WIDTH-OUT_WIDTH-1]) begin
      if (t == OUT_MAX) t = OUT_MAX;
      else              t = t + OUT_WIDTH'(1);
    end
`else
    if (s[IN_WIDTH-OUT_WIDTH-1] && (t == OUT_MAX)) t = OUT_MAX;
`endif
    return t;
  endfunction

  // Write side / block tracking
  logic [CNT_W-1:0]        wcnt_q, wcnt_d;
  logic                    wbank_q, wbank_d;
  logic [SHIFT_WIDTH-1:0]  min_re_q, min_re_d, min_im_q, min_im_d;
  logic [SHIFT_WIDTH-1:0]  shift_re_q, shift_re_d, shift_im_q, shift_im_d;
  logic [SHIFT_WIDTH-1:0]  beat_min_re, beat_min_im, run_min_re, run_min_im;
  logic                    close_blk;

  // Read sequencer
  logic                    rd_act_q, rd_act_d;
  logic [CNT_W-1:0]        rcnt_q, rcnt_d;
  logic                    rbank_q, rbank_d;

  // Ping-pong sample buffers
  logic signed [IN_WIDTH-1:0] mem_i_q [2][BEATS_PER_BLOCK][LANES];
  logic signed [IN_WIDTH-1:0] mem_q_q [2][BEATS_PER_BLOCK][LANES];

  // Read pipeline
  logic                       vld_p1_q, vld_p1_d;
  logic signed [IN_WIDTH-1:0] data_i_p1_q [LANES];
  logic signed [IN_WIDTH-1:0] data_i_p1_d [LANES];
  logic signed [IN_WIDTH-1:0] data_q_p1_q [LANES];
  logic signed [IN_WIDTH-1:0] data_q_p1_d [LANES];
  logic [SHIFT_WIDTH-1:0]     shift_re_p1_q, shift_re_p1_d, shift_im_p1_q, shift_im_p1_d;

  // Output registers
  logic                        valid_out_q, valid_out_d;
  logic signed [OUT_WIDTH-1:0] dout_i_q [LANES];
  logic signed [OUT_WIDTH-1:0] dout_i_d [LANES];
  logic signed [OUT_WIDTH-1:0] dout_q_q [LANES];
  logic signed [OUT_WIDTH-1:0] dout_q_d [LANES];
  logic [SHIFT_WIDTH-1:0]      index_re_q, index_re_d, index_im_q, index_im_d;

  always_comb begin : beat_minimum
    beat_min_re = MAG_MAX;
    beat_min_im = MAG_MAX;
    for (int l = 0; l < LANES; l++) begin
      beat_min_re = min_sh(beat_min_re, lead_sign(din_i[l]));
      beat_min_im = min_sh(beat_min_im, lead_sign(din_q[l]));
    end
  end

  always_comb begin : capture_ctrl
    close_blk  = din_valid && (wcnt_q == LAST_BEAT);
    // The first beat of a block starts the minimum afresh.
    run_min_re = (wcnt_q == '0) ? beat_min_re : min_sh(min_re_q, beat_min_re);
    run_min_im = (wcnt_q == '0) ? beat_min_im : min_sh(min_im_q, beat_min_im);
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    min_re_d   = min_re_q;
    min_im_d   = min_im_q;
    shift_re_d = shift_re_q;
    shift_im_d = shift_im_q;
    if (din_valid) begin
      wcnt_d   = close_blk ? '0 : wcnt_q + CNT_W'(1);
      min_re_d = close_blk ? MAG_MAX : run_min_re;
      min_im_d = close_blk ? MAG_MAX : run_min_im;
    end
    if (close_blk) begin
      shift_re_d = run_min_re;
      shift_im_d = run_min_im;
      wbank_d    = ~wbank_q;
    end
  end

  // Arming wins over the last read of the previous block; that read uses the current state.
  always_comb begin : read_ctrl
    rd_act_d = rd_act_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    if (rd_act_q) begin
      rcnt_d = rcnt_q + CNT_W'(1);
      if (rcnt_q == LAST_BEAT) rd_act_d = 1'b0;
    end
    if (close_blk) begin
      rd_act_d = 1'b1;
      rcnt_d   = '0;
      rbank_d  = wbank_q;
    end
  end

  always_comb begin : datapath
    vld_p1_d      = rd_act_q;
    data_i_p1_d   = mem_i_q[rbank_q][rcnt_q];
    data_q_p1_d   = mem_q_q[rbank_q][rcnt_q];
    shift_re_p1_d = shift_re_q;
    shift_im_p1_d = shift_im_q;
    valid_out_d   = vld_p1_q;
    index_re_d    = vld_p1_q ? shift_re_p1_q : index_re_q;
    index_im_d    = vld_p1_q ? shift_im_p1_q : index_im_q;
    for (int l = 0; l < LANES; l++) begin
      dout_i_d[l] = vld_p1_q ? normalise(data_i_p1_q[l], shift_re_p1_q) : dout_i_q[l];
      dout_q_d[l] = vld_p1_q ? normalise(data_q_p1_q[l], shift_im_p1_q) : dout_q_q[l];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      min_re_q    <= MAG_MAX;
      min_im_q    <= MAG_MAX;
      shift_re_q  <= MAG_MAX;
      shift_im_q  <= MAG_MAX;
      rd_act_q    <= 1'b0;
      rcnt_q      <= '0;
      rbank_q     <= 1'b0;
      vld_p1_q    <= 1'b0;
      valid_out_q <= 1'b0;
      index_re_q  <= '0;
      index_im_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        dout_i_q[l] <= '0;
        dout_q_q[l] <= '0;
      end
    end else begin
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      min_re_q    <= min_re_d;
      min_im_q    <= min_im_d;
      shift_re_q  <= shift_re_d;
      shift_im_q  <= shift_im_d;
      rd_act_q    <= rd_act_d;
      rcnt_q      <= rcnt_d;
      rbank_q     <= rbank_d;
      // ---- stage p1: buffer read ----
      vld_p1_q    <= vld_p1_d;
      // ---- stage p2: normalise and register outputs ----
      valid_out_q <= valid_out_d;
      index_re_q  <= index_re_d;
      index_im_q  <= index_im_d;
      dout_i_q    <= dout_i_d;
      dout_q_q    <= dout_q_d;
    end
  end

  always_ff @(posedge clk) begin
    if (din_valid) begin
      mem_i_q[wbank_q][wcnt_q] <= din_i;
      mem_q_q[wbank_q][wcnt_q] <= din_q;
    end
    data_i_p1_q   <= data_i_p1_d;
    data_q_p1_q   <= data_q_p1_d;
    shift_re_p1_q <= shift_re_p1_d;
    shift_im_p1_q <= shift_im_p1_d;
  end

  assign valid_out = valid_out_q;
  assign dout_i    = dout_i_q;
  assign dout_q    = dout_q_q;
  assign index_re  = index_re_q;
  assign index_im  = index_im_q;

endmodule

// File: tb/tb_cbfp_block_norm.sv
// Table-driven bench for cbfp_block_norm with a cycle-exact scoreboard of expected output beats.
module tb_cbfp_block_norm;

  localparam int LANES = 16;
  localparam int IW    = 25;
  localparam int OW    = 12;
  localparam int BPB   = 4;
  localparam int SW    = 5;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 din_valid = 1'b0;
  logic signed [IW-1:0] din_i [LANES];
  logic signed [IW-1:0] din_q [LANES];
  logic                 valid_out;
  logic signed [OW-1:0] dout_i [LANES];
  logic signed [OW-1:0] dout_q [LANES];
  logic [SW-1:0]        index_re, index_im;

  cbfp_block_norm #(
    .LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW), .BEATS_PER_BLOCK(BPB), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
    .valid_out(valid_out), .dout_i(dout_i), .dout_q(dout_q),
    .index_re(index_re), .index_im(index_im)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic signed [IW-1:0] re, im;
    int                   sp_lane, sp_beat;
    logic signed [IW-1:0] sp_val;
    int                   gap;
    int                   ire, iim;
    logic signed [OW-1:0] ere, eim, esp;
  } vec_t;

  typedef struct {
    int                   cyc;
    int                   ire, iim;
    logic signed [OW-1:0] di [LANES];
    logic signed [OW-1:0] dq [LANES];
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int re, input int im, input int sl, input int sbt,
                              input int sv, input int gap, input int ire, input int iim,
                              input int ere, input int eim, input int esp);
    vec_t v;
    v.re = IW'(re);       v.im = IW'(im);
    v.sp_lane = sl;       v.sp_beat = sbt;    v.sp_val = IW'(sv);
    v.gap = gap;          v.ire = ire;        v.iim = iim;
    v.ere = OW'(ere);     v.eim = OW'(eim);   v.esp = OW'(esp);
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic drive_beat(input vec_t v, input int b);
    @(negedge clk);
    din_valid = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      din_i[l] = (b == v.sp_beat && l == v.sp_lane) ? v.sp_val : v.re;
      din_q[l] = v.im;
    end
  endtask

  // Drives one block; idle gap cycles carry junk data that must be ignored.
  task automatic run_block(input vec_t v, output int t_last);
    exp_t e;
    for (int b = 0; b < BPB; b++) begin
      if (b > 0) begin
        repeat (v.gap) begin
          @(negedge clk);
          din_valid = 1'b0;
          for (int l = 0; l < LANES; l++) begin
            din_i[l] = IW'($urandom);
            din_q[l] = IW'($urandom);
          end
        end
      end
      drive_beat(v, b);
    end
    t_last = cyc + 1;
    for (int k = 0; k < BPB; k++) begin
      e.cyc = t_last + 2 + k;
      e.ire = v.ire;
      e.iim = v.iim;
      for (int l = 0; l < LANES; l++) begin
        e.di[l] = (k == v.sp_beat && l == v.sp_lane) ? v.esp : v.ere;
        e.dq[l] = v.eim;
      end
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   bad_i, bad_q, first_i, first_q;
    if (valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("beat_cycle", cyc, e.cyc);
        chk("index_re", int'(index_re), e.ire);
        chk("index_im", int'(index_im), e.iim);
        bad_i = 0; bad_q = 0; first_i = -1; first_q = -1;
        for (int l = 0; l < LANES; l++) begin
          if (dout_i[l] != e.di[l]) begin
            bad_i++;
            if (first_i < 0) first_i = l;
          end
          if (dout_q[l] != e.dq[l]) begin
            bad_q++;
            if (first_q < 0) first_q = l;
          end
        end
        if (first_i < 0) chk("dout_i_lanes", 0, 0 + bad_i);
        else chk($sformatf("dout_i_lane%0d", first_i), int'(dout_i[first_i]), int'(e.di[first_i]));
        if (first_q < 0) chk("dout_q_lanes", 0, 0 + bad_q);
        else chk($sformatf("dout_q_lane%0d", first_q), int'(dout_q[first_q]), int'(e.dq[first_q]));
      end
    end
  end

  initial begin
    int t;
    int rnd_im;
`ifdef CBFP_ROUND_EN
    rnd_im = 1025;
`else
    rnd_im = 1024;
`endif
    //            re        im     sl  sb  spike     gap ire iim  ere    eim    esp
    vecs[0] = mk(1,         0,     -1, -1, 0,        0,  23, 24,  1024,  0,     0);
    vecs[1] = mk(1,         0,      5,  2, 16777215, 0,  0,  24,  0,     0,     2047);
    vecs[2] = mk(-1,        -1,    -1, -1, 0,        0,  24, 24,  -2048, -2048, 0);
    vecs[3] = mk(1445,      -300,  -1, -1, 0,        3,  13, 15,  1445,  -1200, 0);
    vecs[4] = mk(16,        16,    -1, -1, 0,        0,  19, 19,  1024,  1024,  0);
    vecs[5] = mk(1024,      -1024, -1, -1, 0,        0,  13, 14,  1024,  -2048, 0);
    vecs[6] = mk(1048576,   0,     -1, -1, 0,        0,  3,  24,  1024,  0,     0);
    vecs[7] = mk(4096,      4098,   9,  1, -4096,    2,  11, 11,  1024,  rnd_im, -1024);

    for (int l = 0; l < LANES; l++) begin
      din_i[l] = '0;
      din_q[l] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_valid_out", int'(valid_out), 0);
    chk("reset_index_re", int'(index_re), 0);
    chk("reset_index_im", int'(index_im), 0);
    chk("reset_dout_i0", int'(dout_i[0]), 0);
    chk("reset_dout_q15", int'(dout_q[LANES-1]), 0);
    rstn = 1'b1;
    idle(2);

    // Isolated blocks, including one with idle gaps between beats
    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i], t);
      idle(3);
    end
    idle(4);

    // Three back-to-back blocks: continuous valid_out, index switches at boundaries
    for (int i = 4; i < 7; i++) run_block(vecs[i], t);
    idle(8);

    // Reset after two beats of a block: that block is discarded
    drive_beat(vecs[0], 0);
    drive_beat(vecs[0], 1);
    @(negedge clk);
    din_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_valid_out", int'(valid_out), 0);
    rstn = 1'b1;
    run_block(vecs[5], t);
    idle(8);

    // Reset in the middle of a drain: remaining beats are dropped
    run_block(vecs[4], t);
    din_valid = 1'b1;
    while (cyc < t + 2) begin
      @(negedge clk);
      din_valid = 1'b0;
    end
    rstn = 1'b0;
    @(negedge clk);
    chk("drain_abort_valid_out", int'(valid_out), 0);
    chk("drain_abort_index_re", int'(index_re), 0);
    sb.delete();
    rstn = 1'b1;
    idle(3);

    // Rounding-sensitive block and a negative spike
    run_block(vecs[7], t);
    idle(2);

    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
